// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the request legality check used by both the responder and its users.
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for any request that must be answered with an error: a half not on
  // a 2-byte boundary, a word not on a 4-byte boundary, or the illegal size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channel between the core (master) and the
// data-memory responder (slave). busy travels with the bus for stall logic.
interface dmem_responder_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 10
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_SIZE+1:0]   req_addr;
  logic [WORD_SIZE-1:0]   req_wdata;
  logic [1:0]             req_size;
  logic                   req_sign;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [WORD_SIZE-1:0]   resp_rdata;
  logic                   resp_err;
  logic                   busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_sign,
           resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_sign,
           resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for 32-bit memory: merges a narrow store into the old
// word and extracts/extends a narrow load from the stored word.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  // Store data is LSB-justified; it is placed into the lane chosen by addr_lo.
  function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo);
    logic [31:0] w;
    w = old_w;
    case (size)
      SIZE_BYTE: w[{lo, 3'b000} +: 8]         = wd[7:0];
      SIZE_HALF: w[{lo[1], 4'b0000} +: 16]    = wd[15:0];
      default:   w                            = wd;
    endcase
    return w;
  endfunction

  // Pick the addressed lane and sign- or zero-extend it to a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      SIZE_HALF: r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      SIZE_WORD: r = word;
      default:   r = 32'd0;
    endcase
    return r;
  endfunction

  // Both results are purely combinational views of the current access.
  always_comb begin
    merged_o = store_merge(old_word_i, wdata_i, size_i, addr_lo_i);
    rdata_o  = load_extract(old_word_i, size_i, sign_i, addr_lo_i);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs the access on the edge entering RESP and holds the
// response until the consumer takes it. Misaligned/illegal requests get an
// immediate error response without touching memory.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 1024,
  parameter int ADDR_SIZE = $clog2(NUM_WORDS),
  parameter int LATENCY   = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;

  // Latched request (data only, never reset)
  logic                   write_q;
  logic [ADDR_SIZE+1:0]   addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [1:0]             size_q;
  logic                   sign_q;

  logic [WORD_SIZE-1:0]   mem [NUM_WORDS];

  logic                   accept;
  logic                   commit;
  logic                   acc_write;
  logic [ADDR_SIZE+1:0]   acc_addr;
  logic [WORD_SIZE-1:0]   acc_wdata;
  logic [1:0]             acc_size;
  logic                   acc_sign;
  logic                   acc_err;
  logic [WORD_SIZE-1:0]   old_word;
  logic [WORD_SIZE-1:0]   merged_word;
  logic [WORD_SIZE-1:0]   load_word;

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  // With LATENCY==1 the access happens on the accept edge itself, so the
  // access fields come straight from the bus in IDLE and from the latch later.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = bus.req_write;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_size  = bus.req_size;
      acc_sign  = bus.req_sign;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_sign  = sign_q;
    end
  end

  assign acc_err  = is_misaligned(acc_size, acc_addr[1:0]);
  assign old_word = mem[acc_addr[ADDR_SIZE+1:2]];

  dmem_lane_align u_align (
    .old_word_i (old_word),
    .wdata_i    (acc_wdata),
    .size_i     (acc_size),
    .sign_i     (acc_sign),
    .addr_lo_i  (acc_addr[1:0]),
    .merged_o   (merged_word),
    .rdata_o    (load_word)
  );

  // Next-state, counter and response data; commit marks the edge into RESP
  // that carries a real memory access.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    commit        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (acc_err) begin
            state_d      = ST_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (LATENCY == 1) begin
            state_d      = ST_RESP;
            commit       = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = acc_write ? '0 : load_word;
          end else begin
            state_d      = ST_WAIT;
            cnt_d        = 4'(LATENCY - 2);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          commit       = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = acc_write ? '0 : load_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Control and response registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Request latch, loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      size_q  <= bus.req_size;
      sign_q  <= bus.req_sign;
    end
  end

  // Synchronous RAM write; held off while reset is asserted so an aborted
  // store never lands.
  always_ff @(posedge clk) begin
    if (rst && commit && acc_write) begin
      mem[acc_addr[ADDR_SIZE+1:2]] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios followed by random traffic,
// all checked against a word-array reference model of the memory.
module tb_dmem_responder;
  localparam int LAT = 2;
  localparam int NW  = 1024;
  localparam int AS  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if #(.WORD_SIZE(32), .ADDR_SIZE(AS)) bus ();

  dmem_responder #(
    .WORD_SIZE (32),
    .NUM_WORDS (NW),
    .LATENCY   (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [NW];

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input int sz, input int a);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input int a, input int sz, input bit sgn);
    logic [31:0] w, v;
    int sh;
    w  = mem_m[a / 4];
    sh = (a % 4) * 8;
    if (sz == 0) begin
      v = (w >> sh) & 32'hFF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> sh) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic m_store(input int a, input int sz, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = (a % 4) * 8;
    mem_m[a / 4] = (mem_m[a / 4] & ~(mask << sh)) | ((wd & mask) << sh);
  endtask

  // One complete request/response, with optional response back-pressure.
  task automatic xact(input bit wr, input int a, input logic [31:0] wd,
                      input int sz, input bit sgn, input int hold,
                      input string tag, output logic [31:0] r_obs);
    bit          e;
    logic [31:0] exp_r, r0;
    logic        e0;
    int          lat, wait_n;
    e     = m_err(sz, a);
    exp_r = (e || wr) ? 32'd0 : m_load(a, sz, sgn);
    if (!e && wr) m_store(a, sz, wd);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = (AS+2)'(a);
    bus.req_wdata = wd;
    bus.req_size  = 2'(sz);
    bus.req_sign  = sgn;
    wait_n = 0;
    while (!bus.req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq({tag, " accept"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), e ? 32'd1 : 32'(LAT));
    check_eq({tag, " rdata"}, bus.resp_rdata, exp_r);
    check_eq({tag, " err"}, 32'(bus.resp_err), 32'(e));
    check_eq({tag, " busy"}, 32'(bus.busy), 32'd1);
    r_obs = bus.resp_rdata;
    r0    = bus.resp_rdata;
    e0    = bus.resp_err;

    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      check_eq({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
      check_eq({tag, " hold rdata"}, bus.resp_rdata, r0);
      check_eq({tag, " hold err"}, 32'(bus.resp_err), 32'(e0));
      check_eq({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
      check_eq({tag, " hold busy"}, 32'(bus.busy), 32'd1);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check_eq({tag, " clr valid"}, 32'(bus.resp_valid), 32'd0);
    check_eq({tag, " clr rdata"}, bus.resp_rdata, 32'd0);
    check_eq({tag, " clr err"}, 32'(bus.resp_err), 32'd0);
    check_eq({tag, " ready again"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    check_eq({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check_eq({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    check_eq({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
    check_eq({tag, " busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = 2'b00;
    bus.req_sign   = 1'b0;
    bus.resp_ready = 1'b0;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Known contents for the 16 words the rest of the bench touches.
    for (int i = 0; i < 16; i++) xact(1'b1, i * 4, $urandom, 2, 1'b0, 0, "init", r);

    // Word store/load round trip
    xact(1'b1, 'h010, 32'hDEAD_BEEF, 2, 1'b0, 0, "t1 sw", r);
    xact(1'b0, 'h010, 32'h0, 2, 1'b0, 0, "t1 lw", r);
    check_eq("t1 lw const", r, 32'hDEAD_BEEF);

    // Byte merge and byte/word loads
    xact(1'b1, 'h010, 32'h1122_3344, 2, 1'b0, 0, "t2 sw", r);
    xact(1'b1, 'h013, 32'h0000_00AB, 0, 1'b0, 0, "t2 sb", r);
    xact(1'b0, 'h013, 32'h0, 0, 1'b1, 0, "t2 lb", r);
    check_eq("t2 lb const", r, 32'hFFFF_FFAB);
    xact(1'b0, 'h013, 32'h0, 0, 1'b0, 0, "t2 lbu", r);
    check_eq("t2 lbu const", r, 32'h0000_00AB);
    xact(1'b0, 'h010, 32'h0, 2, 1'b0, 0, "t2 lw", r);
    check_eq("t2 lw const", r, 32'hAB22_3344);

    // Upper half loads
    xact(1'b1, 'h010, 32'h8001_5A5A, 2, 1'b0, 0, "t3 sw", r);
    xact(1'b0, 'h012, 32'h0, 1, 1'b1, 0, "t3 lh", r);
    check_eq("t3 lh const", r, 32'hFFFF_8001);
    xact(1'b0, 'h012, 32'h0, 1, 1'b0, 0, "t3 lhu", r);
    check_eq("t3 lhu const", r, 32'h0000_8001);

    // Error requests, then readback shows memory untouched
    xact(1'b0, 'h011, 32'h0, 2, 1'b0, 0, "t4 lw mis", r);
    xact(1'b1, 'h003, 32'hFFFF_FFFF, 1, 1'b0, 0, "t4 sh mis", r);
    xact(1'b1, 'h000, 32'hFFFF_FFFF, 3, 1'b0, 0, "t4 size3", r);
    xact(1'b0, 'h000, 32'h0, 2, 1'b0, 0, "t4 rb0", r);
    xact(1'b0, 'h010, 32'h0, 2, 1'b0, 0, "t4 rb10", r);
    check_eq("t4 rb10 const", r, 32'h8001_5A5A);

    // Back-pressure for 5 cycles with a pending request held
    xact(1'b0, 'h010, 32'h0, 2, 1'b0, 5, "t5 hold", r);

    // Reset during WAIT discards the store
    xact(1'b1, 'h020, 32'hCAFE_F00D, 2, 1'b0, 0, "t6 sw old", r);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = (AS+2)'('h020);
    bus.req_wdata = 32'h1234_5678;
    bus.req_size  = 2'b10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_eq("t6 busy in wait", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("t6 in reset");
    @(posedge clk);
    #1;
    chk_idle_outputs("t6 reset edge");
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 'h020, 32'h0, 2, 1'b0, 0, "t6 lw", r);
    check_eq("t6 lw const", r, 32'hCAFE_F00D);

    // Random traffic over the initialized region
    for (int i = 0; i < 80; i++) begin
      xact(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom,
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 2)), "rnd", r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
